// File: rtl/debounce_x8_if.sv
// Lane bundle between the raw J1 pins and the debounced consumers.
interface debounce_x8_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] O;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;
    logic             ANY;

    // Driver side: supplies raw levels, observes debounced results.
    modport master (
        output I,
        input  O,
        input  RISE,
        input  FALL,
        input  ANY
    );

    // Debouncer side.
    modport slave (
        input  I,
        output O,
        output RISE,
        output FALL,
        output ANY
    );
endinterface

// File: rtl/debounce_x8.sv
// Eight-lane switch debouncer: two-flop synchronizer, per-lane stability counter,
// registered level output and single-cycle rise/fall strobes.
module debounce_x8 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CNT_W = 17
) (
    input  logic          CLK,
    input  logic          RESET,
    debounce_x8_if.slave  bus
);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];

    // Synchronizer; s1 may go metastable so it feeds nothing but s2.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.I;
            s2_q <= s1_q;
        end
    end

    // Per lane: count consecutive disagreement, flip and strobe once it reaches LIMIT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < WIDTH; n++) begin
                rise_q[n] <= 1'b0;
                fall_q[n] <= 1'b0;
                if (s2_q[n] == o_q[n]) begin
                    // Any agreement throws away the partial count (glitch rejection).
                    cnt_q[n] <= '0;
                end else if (cnt_q[n] == CntMax) begin
                    o_q[n]    <= s2_q[n];
                    cnt_q[n]  <= '0;
                    rise_q[n] <= s2_q[n];
                    fall_q[n] <= ~s2_q[n];
                end else begin
                    cnt_q[n] <= cnt_q[n] + CntOne;
                end
            end
        end
    end

    assign bus.O    = o_q;
    assign bus.RISE = rise_q;
    assign bus.FALL = fall_q;
    assign bus.ANY  = |(rise_q | fall_q);
endmodule

// File: tb/tb_debounce_x8.sv
// Bench for debounce_x8: directed test-plan scenarios plus random lane activity,
// checked by a window-based reference model through a scoreboard queue.
module tb_debounce_x8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned LIMIT = 4;

    typedef struct packed {
        logic [7:0] o;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [7:0] in;
    } samp_t;

    logic clk = 1'b0;
    logic rst;

    debounce_x8_if #(.WIDTH(WIDTH)) dbi ();

    debounce_x8 #(
        .WIDTH(WIDTH),
        .LIMIT(LIMIT),
        .CNT_W(17)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (dbi)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    exp_t       sb[$];
    samp_t      hist[$];
    logic [7:0] win[$];
    logic [7:0] mo;

    // Model: the level seen by the comparator at edge t is the input applied before
    // edge t-2 (zero if a reset hit t-1 or t-2). A lane flips when the last LIMIT
    // such levels all differ from its current output.
    task automatic step(input logic r, input logic [7:0] in);
        exp_t       e;
        samp_t      s;
        logic [7:0] seen;
        logic [7:0] flip;
        rst   = r;
        dbi.I = in;
        s.rst = r;
        s.in  = in;
        hist.push_back(s);
        if (hist.size() > 3) void'(hist.pop_front());
        e.o    = 8'h00;
        e.rise = 8'h00;
        e.fall = 8'h00;
        e.any  = 1'b0;
        if (r) begin
            mo = 8'h00;
            win.delete();
        end else begin
            seen = (hist[1].rst || hist[0].rst) ? 8'h00 : hist[0].in;
            win.push_back(seen);
            if (win.size() > LIMIT) void'(win.pop_front());
            flip = 8'h00;
            if (win.size() == LIMIT) begin
                flip = 8'hFF;
                foreach (win[j]) flip &= win[j] ^ mo;
            end
            e.rise = flip & ~mo;
            e.fall = flip & mo;
            mo     = mo ^ flip;
            e.o    = mo;
            e.any  = |flip;
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output cycle is compared against the next queued expectation.
    initial begin : monitor
        exp_t want;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                want = sb.pop_front();
                got  = {dbi.O, dbi.RISE, dbi.FALL, dbi.ANY};
                tests++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL scoreboard @%0t: got O=%h RISE=%h FALL=%h ANY=%b, expected O=%h RISE=%h FALL=%h ANY=%b",
                             $time, got.o, got.rise, got.fall, got.any,
                             want.o, want.rise, want.fall, want.any);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        samp_t      seed;
        logic [7:0] cur;
        int         p;
        rst      = 1'b1;
        dbi.I    = 8'h00;
        mo       = 8'h00;
        seed.rst = 1'b1;
        seed.in  = 8'h00;
        hist.push_back(seed);
        hist.push_back(seed);
        @(negedge clk);

        // Reset held with inputs high.
        repeat (3) step(1'b1, 8'hFF);
        chk("reset_o", dbi.O, 8'h00);
        chk("reset_strobes", dbi.RISE | dbi.FALL, 8'h00);
        chk("reset_any", {7'b0, dbi.ANY}, 8'h00);
        // Release with inputs still high: rise lands LIMIT+2 edges after last reset edge.
        repeat (5) step(1'b0, 8'hFF);
        chk("release_o_early", dbi.O, 8'h00);
        step(1'b0, 8'hFF);
        chk("release_o", dbi.O, 8'hFF);
        chk("release_rise", dbi.RISE, 8'hFF);
        chk("release_any", {7'b0, dbi.ANY}, 8'h01);
        step(1'b0, 8'hFF);
        chk("release_rise_clear", dbi.RISE, 8'h00);

        // Latency on lane 3.
        repeat (8) step(1'b0, 8'h00);
        chk("latency_start", dbi.O, 8'h00);
        repeat (5) step(1'b0, 8'h08);
        chk("latency_early", dbi.O, 8'h00);
        step(1'b0, 8'h08);
        chk("latency_o", dbi.O, 8'h08);
        chk("latency_rise", dbi.RISE, 8'h08);
        chk("latency_fall", dbi.FALL, 8'h00);

        // Glitch on lane 0: 1,1,1,0 then steady 1.
        repeat (8) step(1'b0, 8'h00);
        repeat (3) step(1'b0, 8'h01);
        step(1'b0, 8'h00);
        repeat (5) step(1'b0, 8'h01);
        chk("glitch_hold", dbi.O, 8'h00);
        step(1'b0, 8'h01);
        chk("glitch_o", dbi.O, 8'h01);

        // Bounce on lane 5, then steady high.
        repeat (8) step(1'b0, 8'h00);
        for (int i = 0; i < 20; i++) step(1'b0, (i % 2 == 0) ? 8'h20 : 8'h00);
        chk("bounce_hold", dbi.O, 8'h00);
        repeat (5) step(1'b0, 8'h20);
        chk("bounce_early", dbi.O, 8'h00);
        step(1'b0, 8'h20);
        chk("bounce_o", dbi.O, 8'h20);
        chk("bounce_rise", dbi.RISE, 8'h20);

        // Simultaneous flips in both directions.
        repeat (8) step(1'b0, 8'h0F);
        chk("simul_start", dbi.O, 8'h0F);
        repeat (6) step(1'b0, 8'hF0);
        chk("simul_o", dbi.O, 8'hF0);
        chk("simul_rise", dbi.RISE, 8'hF0);
        chk("simul_fall", dbi.FALL, 8'h0F);
        chk("simul_any", {7'b0, dbi.ANY}, 8'h01);

        // Reset after two counting edges on lane 7.
        repeat (8) step(1'b0, 8'h00);
        repeat (4) step(1'b0, 8'h80);
        step(1'b1, 8'h80);
        chk("midreset_o", dbi.O, 8'h00);
        repeat (5) step(1'b0, 8'h80);
        chk("midreset_early", dbi.O, 8'h00);
        step(1'b0, 8'h80);
        chk("midreset_o_rise", dbi.O, 8'h80);
        chk("midreset_rise", dbi.RISE, 8'h80);

        // Random lane activity with varying bounce density and occasional reset.
        cur = 8'h00;
        p   = 6;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) p = int'($urandom_range(2, 14));
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, p - 1) == 0) cur[b] = ~cur[b];
            end
            step(($urandom_range(0, 99) == 0), cur);
        end

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/debounce_x8.md
# debounce_x8

Eight-lane switch debouncer that conditions the raw J1 board inputs before they reach the NOr2x4 logic stage. Each lane passes through a two-flop synchronizer and a per-lane stability counter. A lane's output changes only after its synchronized input has disagreed with the current output for LIMIT consecutive cycles. Single-cycle edge strobes per lane are also provided for downstream sequential consumers.

## Interface
- WIDTH, 8: number of independent lanes (J1 is 8 bits).
- LIMIT, 4: consecutive disagreeing cycles required before a lane's output flips; must be ≥ 1. Board builds use 120000 (10 ms at 12 MHz).
- CNT_W, 17: stability counter width; must satisfy 2^CNT_W > LIMIT-1.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- I  in  WIDTH  raw asynchronous lane inputs (J1 pins).
- O  out  WIDTH  debounced lane levels; feeds NOr2x4 I0/I1.
- RISE  out  WIDTH  one-cycle pulse when O[n] goes 0→1.
- FALL  out  WIDTH  one-cycle pulse when O[n] goes 1→0.
- ANY  out  1  OR-reduction of RISE|FALL, same cycle.

## Operation
- Per lane n, with independent state: s1[n] <= I[n]; s2[n] <= s1[n]; counter cnt[n] (CNT_W bits); output register O[n].
- Each edge, when RESET=0:
  - s2[n] == O[n]: cnt[n] <= 0; O[n] holds.
  - s2[n] != O[n] and cnt[n] == LIMIT-1: O[n] <= s2[n]; cnt[n] <= 0; RISE[n] or FALL[n] <= 1 per direction.
  - s2[n] != O[n] otherwise: cnt[n] <= cnt[n]+1.
- RISE/FALL are registered and are 0 on every edge that does not flip the lane. Both are never 1 on the same lane.
- Any single-cycle agreement of s2 with O discards accumulated count (glitch rejection). Bounce shorter than LIMIT cycles never reaches O.
- The counter never exceeds LIMIT-1 and never wraps. LIMIT=1 flips on the first disagreeing cycle.
- Lanes are fully independent. Simultaneous flips on several lanes assert several RISE/FALL bits in one cycle, with ANY=1 once.
- The block contains no combinational path from I to any output. O, RISE and FALL are direct register outputs; ANY is a single OR gate on registers.

## Timing
- Reset (RESET=1 at an edge): s1, s2, cnt, O, RISE and FALL all become 0. ANY is therefore 0. Reset overrides all other updates.
- Reset mid-count discards the count. Reset while O[n]=1 forces O[n]=0 with no FALL pulse. If I[n] is still high, the lane re-rises LIMIT+2 edges after the last reset edge.
- Latency: I[n] changes and is stable before edge k. s1 updates at k, s2 at k+1. O[n] and the strobe update at edge k+1+LIMIT. With LIMIT=4, k=0, O flips at edge 5.
- Throughput: a lane can flip at most once per LIMIT cycles after the input is stable.
- Metastability is confined to s1. s1 must not fan out anywhere except s2.

## Test plan
- Reset: hold RESET=1 with I=8'hFF for 3 edges → O=8'h00, RISE=FALL=8'h00, ANY=0. Release at edge 0 with I held at 8'hFF → O=8'hFF, RISE=8'hFF and ANY=1 at edge 6 only (LIMIT=4); RISE returns to 0 at edge 7.
- Latency: from O=0, set I[3]=1 before edge k → O[3]=1 and RISE[3]=1 exactly at edge k+5; FALL=0 throughout; other lanes unchanged.
- Glitch rejection: from O=0, drive I[0]=1 for 3 cycles, 0 for 1 cycle, 1 again → no flip at the expected first deadline. O[0] rises 5 edges after the final 0→1 transition.
- Bounce: toggle I[5] every cycle for 20 cycles, then hold at 1 → O[5] stays 0 during toggling, then rises 5 edges after the hold begins with a single RISE pulse.
- Simultaneous lanes: with O=8'h0F, set I=8'hF0 in one cycle → at one edge O=8'hF0, RISE=8'hF0, FALL=8'h0F, ANY=1.
- Reset mid-count: raise I[7], assert RESET for one edge after 2 counting edges → O[7]=0, no RISE. O[7] rises 6 edges after the reset edge.
